// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// reset defaults, the configuration record and a width helper.
package seq_det_pkg;

    // Widest pattern the configuration record can carry.
    localparam int MAX_PAT_W = 32;

    // Reset defaults used by the top level.
    localparam logic [3:0] DEF_PATTERN_4 = 4'b1010;
    localparam int         DEF_CNT_W     = 8;

    // Runtime configuration. Fields are sized for the widest pattern;
    // bits above PAT_W stay zero so they never influence a compare.
    typedef struct packed {
        logic [MAX_PAT_W-1:0] pattern;
        logic [MAX_PAT_W-1:0] mask;
        logic                 overlap;
    } seq_cfg_t;

    // Ceiling log2, used to size the fill counter (argument is PAT_W+1).
    function automatic int clog2(input int value);
        int result;
        int one;
        result = 0;
        one    = 1;
        for (int i = 0; i < 31; i++) begin
            if ((one << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// Serial history window: shift register of accepted bits plus a saturating
// fill counter telling how many bits since the last clear/restart are valid.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W  = 4,
    parameter int FILL_W = clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             x,
    input  logic             clear,
    input  logic             restart_fill,
    output logic [PAT_W-1:0] history_n,
    output logic             full_n
);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    logic [PAT_W-1:0]  history_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_inc_s;

    // Next history/fill as they would be after this edge; full_n is only
    // asserted when a bit is actually shifted in.
    always_comb begin
        history_n  = history_q;
        fill_inc_s = fill_q;
        full_n     = 1'b0;
        if (fill_q == FILL_MAX) begin
            fill_inc_s = FILL_MAX;
        end else begin
            fill_inc_s = fill_q + FILL_ONE;
        end
        if (shift_en) begin
            history_n = {history_q[PAT_W-2:0], x};
            full_n    = (fill_inc_s == FILL_MAX);
        end else begin
            history_n = history_q;
            full_n    = 1'b0;
        end
    end

    // Window registers; a non-overlap hit restarts the fill count while
    // the history keeps shifting.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history_q <= {PAT_W{1'b0}};
            fill_q    <= FILL_ZERO;
        end else if (shift_en) begin
            history_q <= history_n;
            fill_q    <= restart_fill ? FILL_ZERO : fill_inc_s;
        end else begin
            history_q <= history_q;
            fill_q    <= fill_q;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector: programmable pattern with per-bit
// don't-care mask, overlap/non-overlap modes, one-cycle detect pulse and a
// saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_4),
    parameter bit               DEF_OVERLAP = 1'b1,
    parameter int               CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam seq_cfg_t RST_CFG = '{
        pattern: MAX_PAT_W'(DEF_PATTERN),
        mask:    MAX_PAT_W'({PAT_W{1'b1}}),
        overlap: DEF_OVERLAP
    };
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    seq_cfg_t         cfg_q;
    seq_cfg_t         cfg_d;
    logic             detect_q;
    logic             detect_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat_q;
    logic             sat_d;

    logic             shift_en_s;
    logic             hit_s;
    logic             restart_fill_s;
    logic [PAT_W-1:0] history_n_s;
    logic             full_n_s;

    // A configuration load takes priority over the data strobe: that bit is dropped.
    assign shift_en_s = x_valid & ~cfg_load;

    seq_det_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .shift_en     (shift_en_s),
        .x            (x),
        .clear        (cfg_load),
        .restart_fill (restart_fill_s),
        .history_n    (history_n_s),
        .full_n       (full_n_s)
    );

    // Masked compare of the next history against the pattern, plus next
    // values for config, detect and the saturating counter.
    always_comb begin
        cfg_d          = cfg_q;
        hit_s          = 1'b0;
        restart_fill_s = 1'b0;
        detect_d       = 1'b0;
        count_d        = count_q;
        sat_d          = sat_q;

        // Compare in the full record width; upper bits are zero on both sides.
        if (shift_en_s && full_n_s &&
            (((MAX_PAT_W'(history_n_s) ^ cfg_q.pattern) & cfg_q.mask) == {MAX_PAT_W{1'b0}})) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        restart_fill_s = hit_s & ~cfg_q.overlap;
        detect_d       = hit_s;

        if (cfg_load) begin
            cfg_d = '{
                pattern: MAX_PAT_W'(cfg_pattern),
                mask:    MAX_PAT_W'(cfg_mask),
                overlap: cfg_overlap
            };
            count_d = CNT_ZERO;
        end else if (hit_s && (count_q != CNT_MAX)) begin
            cfg_d   = cfg_q;
            count_d = count_q + CNT_ONE;
        end else begin
            cfg_d   = cfg_q;
            count_d = count_q;
        end
        sat_d = (count_d == CNT_MAX);
    end

    // Config, detect and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q    <= RST_CFG;
            detect_q <= 1'b0;
            count_q  <= CNT_ZERO;
            sat_q    <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            detect_q <= detect_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
        end
    end

    assign detect      = detect_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
// Two instances share the stimulus: CNT_W=8 and CNT_W=2 (saturation).
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic [3:0] cfg_mask = 4'b0000;
    logic       cfg_overlap = 1'b0;

    logic       det_a, det_b, sat_a, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: accepted bits since last clear, newest last.
    bit         m_hist[$];
    int         m_since;
    int         m_hits;
    bit         m_det;
    logic [3:0] m_pat;
    logic [3:0] m_mask;
    bit         m_ov;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_W(4), .DEF_PATTERN(4'b1010), .DEF_OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .detect(det_a), .match_count(cnt_a), .count_sat(sat_a)
    );

    seq_det_param #(.PAT_W(4), .DEF_PATTERN(4'b1010), .DEF_OVERLAP(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap),
        .detect(det_b), .match_count(cnt_b), .count_sat(sat_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1ns later.
    task automatic step(input logic r, input logic v, input logic xb, input logic ld);
        bit ok;
        reset    = r;
        x_valid  = v;
        x        = xb;
        cfg_load = ld;
        @(posedge clk);
        if (r) begin
            m_pat = 4'b1010; m_mask = 4'b1111; m_ov = 1'b1;
            m_hist.delete(); m_since = 0; m_hits = 0; m_det = 1'b0;
        end else if (ld) begin
            m_pat = cfg_pattern; m_mask = cfg_mask; m_ov = cfg_overlap;
            m_hist.delete(); m_since = 0; m_hits = 0; m_det = 1'b0;
        end else if (v) begin
            m_hist.push_back(xb);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            if (m_since < 4) m_since++;
            m_det = 1'b0;
            if (m_since == 4) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (m_mask[i] && (m_hist[m_hist.size() - 1 - i] != m_pat[i])) ok = 1'b0;
                end
                m_det = ok;
            end
            if (m_det) begin
                m_hits++;
                if (!m_ov) m_since = 0;
            end
        end else begin
            m_det = 1'b0;
        end
        #1;
        check("detect_a", {31'd0, det_a}, {31'd0, m_det});
        check("detect_b", {31'd0, det_b}, {31'd0, m_det});
        check("count_a", {24'd0, cnt_a}, (m_hits > 255) ? 32'd255 : 32'(m_hits));
        check("sat_a", {31'd0, sat_a}, (m_hits >= 255) ? 32'd1 : 32'd0);
        check("count_b", {30'd0, cnt_b}, (m_hits > 3) ? 32'd3 : 32'(m_hits));
        check("sat_b", {31'd0, sat_b}, (m_hits >= 3) ? 32'd1 : 32'd0);
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic ov);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = ov;
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Send n bits MSB first, with gap idle cycles (random x) after each bit.
    task automatic send(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    int pulses;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_count", {24'd0, cnt_a}, 32'd0);
        check("rst_detect", {31'd0, det_a}, 32'd0);

        // Defaults, overlapping: hits after bits 4 and 6.
        send(16'b101010, 6, 0);
        check("t1_count", {24'd0, cnt_a}, 32'd2);

        // Non-overlapping: hits after bits 4 and 8 only.
        load(4'b1010, 4'b1111, 1'b0);
        send(16'b10101010, 8, 0);
        check("t2_count", {24'd0, cnt_a}, 32'd2);

        // Valid gaps of 3 idle cycles: exactly one pulse.
        load(4'b1010, 4'b1111, 1'b1);
        pulses = 0;
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'(4'b1010 >> i), 1'b0);
            if (det_a) pulses++;
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (det_a) pulses++;
            end
        end
        check("t3_pulses", 32'(pulses), 32'd1);

        // Don't-care mask.
        load(4'b1001, 4'b1001, 1'b1);
        send(16'b1111, 4, 0);
        check("t4_1111", {24'd0, cnt_a}, 32'd1);
        load(4'b1001, 4'b1001, 1'b1);
        send(16'b1001, 4, 0);
        check("t4_1001", {24'd0, cnt_a}, 32'd1);
        load(4'b1001, 4'b1001, 1'b1);
        send(16'b0111, 4, 0);
        check("t4_0111", {24'd0, cnt_a}, 32'd0);

        // Reset mid-sequence discards partial history.
        load(4'b1010, 4'b1111, 1'b1);
        send(16'b101, 3, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b0, 1, 0);
        check("t5_nodet", {24'd0, cnt_a}, 32'd0);
        send(16'b1010, 4, 0);
        check("t5_det", {24'd0, cnt_a}, 32'd1);

        // Saturation of the 2-bit counter: six hits in 14 bits.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b10101010101010, 14, 0);
        check("t6_cnt_a", {24'd0, cnt_a}, 32'd6);
        check("t6_cnt_b", {30'd0, cnt_b}, 32'd3);
        check("t6_sat_b", {31'd0, sat_b}, 32'd1);

        // Randomized traffic with occasional reloads and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 59) == 0) begin
                load(4'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
